// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch sequencer and its prefetch queue.
package rvx_fetch_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        fault;
   } fetch_entry_t;

endpackage

// File: rtl/imem_fetch_ctrl_fifo.sv
// Synchronous FIFO for prefetched {pc, instr, fault} entries; flush outranks push and pop.
module fetch_fifo
   import rvx_fetch_pkg::*;
#(
   parameter int  DEPTH   = 4,
   parameter type entry_t = fetch_entry_t
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  entry_t                 wdata,
   output entry_t                 rdata,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);

   entry_t          mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;

   // NOTE: the storage array has no reset; pointers and count decide which slots hold live data.
   always_ff @(posedge clk) begin
      if (push && !flush && !reset) begin
         mem[wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign rdata = mem[rd_ptr];

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: walks the ROM address, queues {pc, instr, fault} entries
// and hands them to decode over valid/ready; redirects flush and restart the stream.
module imem_fetch_ctrl
   import rvx_fetch_pkg::*;
#(
   parameter int          DEPTH      = 4,
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          IMEM_WORDS = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        fetch_en,
   output logic [31:0] imem_a,
   input  logic [31:0] imem_rd,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   output logic        out_fault,
   output logic        fetch_halted
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [31:0]   fetch_pc;
   logic          halted;
   logic [CW-1:0] count;
   logic          push;
   logic          pop;
   logic          fault;
   fetch_entry_t  wentry;
   fetch_entry_t  head;

   assign fault = (fetch_pc[31:2] >= 30'(IMEM_WORDS));

   // A redirect cycle consumes nothing, so pop is masked here as well as by the flush.
   assign pop  = out_valid & out_ready & ~redirect_valid;
   assign push = fetch_en & ~halted & ~redirect_valid &
                 ((count < CW'(DEPTH)) | pop);

   always_comb begin
      wentry       = '0;
      wentry.pc    = fetch_pc;
      wentry.instr = fault ? NOP_INSTR : imem_rd;
      wentry.fault = fault;
   end

   // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc <= RESET_PC;
         halted   <= 1'b0;
      end else if (redirect_valid) begin
         fetch_pc <= redirect_pc & ~32'd3;
         halted   <= 1'b0;
      end else if (push) begin
         if (fault) begin
            halted <= 1'b1;
         end else begin
            fetch_pc <= fetch_pc + 32'd4;
         end
      end
   end

   fetch_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (fetch_entry_t)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .flush (redirect_valid),
      .wdata (wentry),
      .rdata (head),
      .count (count)
   );

   assign imem_a       = fetch_pc;
   assign fetch_halted = halted;
   assign out_valid    = (count != '0);
   assign out_instr    = out_valid ? head.instr : NOP_INSTR;
   assign out_pc       = out_valid ? head.pc    : 32'h0;
   assign out_fault    = out_valid & head.fault;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl: ROM model with ROM[k]=k+1, hand-computed expectations.
module tb_imem_fetch_ctrl;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset;
   logic        fetch_en;
   logic [31:0] imem_a;
   logic [31:0] imem_rd;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        out_fault;
   logic        fetch_halted;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   // ROM contents: word k holds k+1, returned in the same cycle.
   assign imem_rd = {2'b00, imem_a[31:2]} + 32'd1;

   imem_fetch_ctrl #(
      .DEPTH      (4),
      .RESET_PC   (32'h0000_0000),
      .IMEM_WORDS (64)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .fetch_en       (fetch_en),
      .imem_a         (imem_a),
      .imem_rd        (imem_rd),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .out_fault      (out_fault),
      .fetch_halted   (fetch_halted)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // One rising edge, then settle to the falling edge where checks and new inputs happen.
   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
   endtask

   initial begin
      reset          = 1'b1;
      fetch_en       = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      out_ready      = 1'b1;
      @(negedge clk);

      // 1. reset state and back-to-back streaming
      tick(2);
      check("rst_valid",  32'(out_valid),    32'd0);
      check("rst_instr",  out_instr,         NOP);
      check("rst_pc",     out_pc,            32'h0);
      check("rst_fault",  32'(out_fault),    32'd0);
      check("rst_halted", 32'(fetch_halted), 32'd0);
      check("rst_imem_a", imem_a,            32'h0);
      reset = 1'b0;
      tick();
      for (int i = 0; i < 6; i++) begin
         check($sformatf("t1_valid%0d", i), 32'(out_valid), 32'd1);
         check($sformatf("t1_pc%0d", i),    out_pc,         32'(4 * i));
         check($sformatf("t1_instr%0d", i), out_instr,      32'(i + 1));
         tick();
      end

      // 2. stall with out_ready=0, then drain with pass-through at full
      out_ready = 1'b0;
      do_reset();
      tick(10);
      check("t2_valid",  32'(out_valid), 32'd1);
      check("t2_hold",   out_pc,         32'h0);
      check("t2_stall",  imem_a,         32'd16);
      out_ready = 1'b1;
      tick();
      check("t2_passthru", imem_a, 32'd20);
      for (int i = 1; i <= 5; i++) begin
         check($sformatf("t2_pc%0d", i),    out_pc,    32'(4 * i));
         check($sformatf("t2_instr%0d", i), out_instr, 32'(i + 1));
         tick();
      end

      // 3. redirect while full, out_ready=1
      out_ready = 1'b0;
      do_reset();
      tick(6);
      check("t3_full_pc", imem_a, 32'd16);
      out_ready      = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0022;
      tick();
      redirect_valid = 1'b0;
      check("t3_flush_valid", 32'(out_valid), 32'd0);
      check("t3_aligned",     imem_a,         32'h20);
      tick();
      check("t3_valid", 32'(out_valid), 32'd1);
      check("t3_pc",    out_pc,         32'h20);
      check("t3_instr", out_instr,      32'd9);

      // 4. run off the end of the ROM
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_00F0;
      tick();
      redirect_valid = 1'b0;
      tick(4);
      check("t4_last_pc",    out_pc,            32'hFC);
      check("t4_last_instr", out_instr,         32'd64);
      check("t4_last_fault", 32'(out_fault),    32'd0);
      tick();
      check("t4_fault_pc",    out_pc,            32'h100);
      check("t4_fault",       32'(out_fault),    32'd1);
      check("t4_fault_instr", out_instr,         NOP);
      check("t4_halted",      32'(fetch_halted), 32'd1);
      tick(3);
      check("t4_no_push",   32'(out_valid),    32'd0);
      check("t4_pc_hold",   imem_a,            32'h100);
      check("t4_still_hlt", 32'(fetch_halted), 32'd1);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0;
      tick();
      redirect_valid = 1'b0;
      check("t4_unhalt", 32'(fetch_halted), 32'd0);
      tick();
      check("t4_resume_pc",    out_pc,    32'h0);
      check("t4_resume_instr", out_instr, 32'd1);

      // 5. reset beats a simultaneous redirect with 3 entries queued
      out_ready = 1'b0;
      do_reset();
      tick(3);
      check("t5_pc_before", imem_a, 32'd12);
      reset          = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h40;
      tick();
      reset          = 1'b0;
      redirect_valid = 1'b0;
      check("t5_valid",  32'(out_valid), 32'd0);
      check("t5_rst_pc", imem_a,         32'h0);
      tick();
      check("t5_head_pc", out_pc, 32'h0);

      // 6. fetch_en=0 drains the queue without moving fetch_pc
      tick(2);
      check("t6_pc_before", imem_a, 32'd12);
      fetch_en  = 1'b0;
      out_ready = 1'b1;
      tick();
      check("t6_d1_pc", out_pc, 32'd4);
      tick();
      check("t6_d2_pc", out_pc, 32'd8);
      tick();
      check("t6_empty",     32'(out_valid), 32'd0);
      check("t6_empty_nop", out_instr,      NOP);
      check("t6_pc_const",  imem_a,         32'd12);
      fetch_en = 1'b1;
      tick();
      check("t6_resume_pc",    out_pc,    32'd12);
      check("t6_resume_instr", out_instr, 32'd4);
      tick();
      check("t6_next_pc", out_pc, 32'd16);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
